// File: rtl/perceptron_driver_if.sv
// Word-protocol bundle between the perceptron_driver (master) and a perceptron core (slave).
interface perceptron_driver_if;
    logic       go;
    logic       update;
    logic       correct;
    logic [5:0] in_val;
    logic [1:0] sel_out;
    logic       done;
    logic       classification;
    logic       sync;
    logic [5:0] out_val;

    modport master (
        output go, update, correct, in_val, sel_out,
        input  done, classification, sync, out_val
    );

    modport slave (
        input  go, update, correct, in_val, sel_out,
        output done, classification, sync, out_val
    );
endinterface

// File: rtl/perceptron_driver.sv
// Host-side sequencer for the perceptron core: loads weights, trains for EPOCHS passes over a
// small table, scores one evaluation pass, then reads the trained weights back.
module perceptron_driver #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned EPOCHS  = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       start,
    input  logic [5:0]                 init_w0,
    input  logic [5:0]                 init_w1,
    input  logic [5:0]                 init_w2,
    input  logic [5:0]                 rate,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [5:0]                 wr_x1,
    input  logic [5:0]                 wr_x2,
    input  logic                       wr_label,
    perceptron_driver_if.master        core,
    output logic                       busy,
    output logic                       finished,
    output logic                       proto_err,
    output logic [$clog2(DEPTH+1)-1:0] mis_count,
    output logic [5:0]                 w0_q,
    output logic [5:0]                 w1_q,
    output logic [5:0]                 w2_q
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(EPOCHS + 2);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] IdxLast  = AW'(DEPTH - 1);
    localparam logic [PW-1:0] PassEval = PW'(EPOCHS);
    localparam logic [TW-1:0] WaitLast = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StLw0, StLw1, StLw2, StLn, StLx1, StLx2, StWait,
        StResult, StRb0, StRb1, StRb2, StFin
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    cfg_w0_q, cfg_w1_q, cfg_w2_q, cfg_rate_q;
    logic [AW-1:0] idx_q;
    logic [PW-1:0] pass_q;
    logic [TW-1:0] wait_q;
    // Entry layout: {label, x2, x1}
    logic [12:0]   table_q [DEPTH];
    logic [12:0]   entry;

    logic       drv_go, drv_update, drv_correct, err_set;
    logic [5:0] drv_in_val;
    logic [1:0] drv_sel;

    always_comb begin
        entry       = table_q[idx_q];
        state_d     = state_q;
        drv_go      = 1'b0;
        drv_in_val  = 6'd0;
        drv_sel     = 2'd0;
        drv_update  = 1'b0;
        drv_correct = 1'b0;
        err_set     = 1'b0;

        // Sample controls stay stable from LX1 until the result is taken.
        if (state_q inside {StLx1, StLx2, StWait, StResult}) begin
            drv_update  = (pass_q < PassEval);
            drv_correct = entry[12];
        end

        unique case (state_q)
            StIdle: if (start) state_d = StLw0;
            StLw0: begin
                drv_go     = 1'b1;
                drv_in_val = cfg_w0_q;
                err_set    = !core.sync;
                state_d    = core.sync ? StLw1 : StFin;
            end
            StLw1: begin
                drv_go     = 1'b1;
                drv_in_val = cfg_w1_q;
                err_set    = !core.sync;
                state_d    = core.sync ? StLw2 : StFin;
            end
            StLw2: begin
                drv_go     = 1'b1;
                drv_in_val = cfg_w2_q;
                err_set    = !core.sync;
                state_d    = core.sync ? StLn : StFin;
            end
            StLn: begin
                drv_go     = 1'b1;
                drv_in_val = cfg_rate_q;
                err_set    = !core.sync;
                state_d    = core.sync ? StLx1 : StFin;
            end
            StLx1: begin
                drv_go     = 1'b1;
                drv_in_val = entry[5:0];
                err_set    = !core.sync;
                state_d    = core.sync ? StLx2 : StFin;
            end
            StLx2: begin
                drv_go     = 1'b1;
                drv_in_val = entry[11:6];
                state_d    = StWait;
            end
            StWait: begin
                if (core.done) begin
                    state_d = StResult;
                end else if (wait_q == WaitLast) begin
                    err_set = 1'b1;
                    state_d = StFin;
                end
            end
            StResult: begin
                if (idx_q != IdxLast || pass_q < PassEval) state_d = StLn;
                else state_d = StRb0;
            end
            StRb0: begin
                drv_sel = 2'd3;
                state_d = StRb1;
            end
            StRb1: begin
                drv_sel = 2'd2;
                state_d = StRb2;
            end
            StRb2: begin
                drv_sel = 2'd1;
                state_d = StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= StIdle;
            cfg_w0_q   <= 6'd0;
            cfg_w1_q   <= 6'd0;
            cfg_w2_q   <= 6'd0;
            cfg_rate_q <= 6'd0;
            idx_q      <= '0;
            pass_q     <= '0;
            wait_q     <= '0;
            proto_err  <= 1'b0;
            mis_count  <= '0;
            w0_q       <= 6'd0;
            w1_q       <= 6'd0;
            w2_q       <= 6'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= (state_q == StWait) ? wait_q + 1'b1 : '0;
            if (err_set) proto_err <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        cfg_w0_q   <= init_w0;
                        cfg_w1_q   <= init_w1;
                        cfg_w2_q   <= init_w2;
                        cfg_rate_q <= rate;
                        proto_err  <= 1'b0;
                        mis_count  <= '0;
                        idx_q      <= '0;
                        pass_q     <= '0;
                    end
                end
                StResult: begin
                    if (pass_q == PassEval && core.classification != entry[12]) begin
                        mis_count <= mis_count + 1'b1;
                    end
                    if (idx_q != IdxLast) begin
                        idx_q <= idx_q + 1'b1;
                    end else begin
                        idx_q  <= '0;
                        pass_q <= pass_q + 1'b1;
                    end
                end
                StRb0:   w0_q <= core.out_val;
                StRb1:   w1_q <= core.out_val;
                StRb2:   w2_q <= core.out_val;
                default: ;
            endcase
        end
    end

    // Training table carries no reset; contents are defined only after host writes.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) table_q[wr_addr] <= {wr_label, wr_x2, wr_x1};
    end

    assign busy         = (state_q != StIdle) && (state_q != StFin);
    assign finished     = (state_q == StFin);
    assign core.go      = drv_go;
    assign core.update  = drv_update;
    assign core.correct = drv_correct;
    assign core.in_val  = drv_in_val;
    assign core.sel_out = drv_sel;
endmodule

// File: doc/perceptron_driver.md
# perceptron_driver

Host-side sequencer for the `perceptron` core: it is the stimulus end of the core's go/sync/done word protocol. It loads initial weights and the learning rate, streams a small on-chip training table for a fixed number of training passes (update=1), then runs one evaluation pass (update=0) counting misclassifications, and finally reads the trained weights back through `sel_out`/`out_val`. It sits between a test or configuration interface and one `perceptron` instance, sharing its clock and reset.

## Interface
- `DEPTH`, 4: number of samples in the training table (power of 2, ≥2).
- `EPOCHS`, 4: number of training passes before the evaluation pass (≥1).
- `TIMEOUT`, 15: maximum cycles spent in WAIT before a protocol error.
- `clk` in 1: clock.
- `reset_l` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `init_w0`, `init_w1`, `init_w2`, `rate` in 6 each: initial weights and learning rate; captured on accepted `start`.
- `wr_en` in 1: table write strobe; ignored while `busy`.
- `wr_addr` in $clog2(DEPTH): table entry to write.
- `wr_x1`, `wr_x2` in 6 each, `wr_label` in 1: sample features and target (1 = +1 class).
- `go`, `update`, `correct` out 1 each: core handshake and control.
- `in_val` out 6: word presented to the core.
- `sel_out` out 2: core readback select (3=w0, 2=w1, 1=w2, 0=sum).
- `done`, `classification`, `sync` in 1 each: from the core.
- `out_val` in 6: core readback data.
- `busy` out 1: high from the cycle after `start` is accepted until FIN.
- `finished` out 1: one-cycle pulse in FIN.
- `proto_err` out 1: sticky; cleared only on accepted `start` or reset.
- `mis_count` out $clog2(DEPTH+1): misclassifications in the evaluation pass.
- `w0_q`, `w1_q`, `w2_q` out 6 each: weights read back after the run.

## Operation
- States: IDLE, LW0, LW1, LW2, LN, LX1, LX2, WAIT, RESULT, RB0, RB1, RB2, FIN.
- IDLE: `go`=0. On `start`, the block captures the config inputs, clears `proto_err`, `mis_count`, sample index and pass counter, then goes to LW0.
- Word phases: each L-state lasts exactly one cycle with `go`=1 and drives the following `in_val`:
  - LW0: init_w0.
  - LW1: init_w1.
  - LW2: init_w2.
  - LN: rate.
  - LX1: x1[idx].
  - LX2: x2[idx].
- Sync check: `sync` must be 1 during LW0, LW1, LW2, LN and LX1. If it is 0, the block sets `proto_err` and goes directly to FIN. LX2 has no sync check.
- `correct` = label[idx] and `update` = (pass < EPOCHS). Both are driven from LX1 through RESULT and held stable throughout.
- WAIT (`go`=0): on `done`=1, go to RESULT. After TIMEOUT cycles in WAIT without `done`, set `proto_err` and go to FIN.
- RESULT (one cycle): sample `classification`. In the evaluation pass, if it differs from label[idx], increment `mis_count`. Then:
  - If idx < DEPTH-1: idx++, go to LN.
  - Otherwise: idx=0, pass++. Go to LN if pass ≤ EPOCHS, else go to RB0.
- Weights and rate are loaded once per run. Every later sample restarts at LN.
- RB0/RB1/RB2: drive `sel_out`=3/2/1 and capture `out_val` into `w0_q`/`w1_q`/`w2_q` in the same cycle.
- FIN: pulse `finished`, then return to IDLE. Results and `proto_err` hold until the next accepted `start`.
- Table: DEPTH×13-bit register array, written on `wr_en` when not `busy`. No reset requirement on the table contents.

## Timing
- Reset values:
  - Outputs: `go`, `update`, `correct`, `busy`, `finished`, `proto_err` = 0; `in_val`, `sel_out`, `mis_count`, `w*_q` = 0.
  - State: IDLE.
- Accepted `start` at cycle t: LW0 (`go`=1) at t+1.
- First sample: go pulses on consecutive cycles t+1..t+6. Each later sample: 3 consecutive go cycles (LN, LX1, LX2).
- `done` from the core arrives 2 cycles after LX2 with `update`=0. With `update`=1 it arrives 3, 6, 9 or 12 cycles after LX2. TIMEOUT=15 covers the worst case.
- `classification` is sampled the cycle after `done` (RESULT), never in the `done` cycle.
- `start` while `busy` is ignored. `wr_en` while `busy` is ignored.
- Reset asserted mid-run returns to IDLE with reset values on the next edge. The core shares the reset, so a new `start` replays the full sequence from LW0.
- `mis_count` saturates only by construction: its maximum value is DEPTH.

## Test plan
- Load samples (x1,x2,label) = (8,0,1),(0,8,1),(56,56,0),(8,8,1); start with w=(0,8,8), rate=4 -> `in_val` at go cycles is 0,8,8,4,8,0; subsequent samples start with 4.
- Same table against a core model that always classifies correctly -> 4×EPOCHS update samples and 4 eval samples; `mis_count`=0; `finished` pulses once; `w*_q` equal the core's final weights.
- Core stub holding `sync`=0 -> `proto_err`=1 and FIN on the cycle after LW0; `finished` pulses; `go` never rises again.
- Core stub that never asserts `done` -> `proto_err` after 15 WAIT cycles, then `finished`.
- Eval-pass stub returning `classification`=0 for all samples with labels 1,1,0,1 -> `mis_count`=3.
- `start` pulsed during WAIT is ignored; `reset_l` low during WAIT -> all outputs at reset values; a new `start` replays from LW0 with `in_val`=init_w0.
